// File: rtl/rtc_scan_display.sv
// rtc_scan_display
// Time-of-day / countdown core with a multiplexed common-anode 7-segment driver.
// A prescaler produces one tick per TICK_DIV clocks; each tick advances
// (clock mode) or decrements (countdown mode) an HH:MM:SS counter. A scan
// counter walks the digits (6 = HH MM SS, 4 = MM SS) and the segment and
// digit-select pins are registered together from one snapshot.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-low reset
//   run        1 = prescaler advances, 0 = prescaler and time frozen
//   mode       0 = count up, 1 = count down
//   load       one-cycle strobe to load load_h/load_m/load_s
//   load_h/m/s value to load (validated: h<=23, m<=59, s<=59)
//   seg        {dp,g,f,e,d,c,b,a}, active-low
//   digit_sel  one-hot active-low digit enable
//   sec_tick   one-cycle pulse per elapsed second
//   done       one-cycle pulse when countdown reaches 00:00:00
//   load_err   one-cycle pulse when a load is rejected
module rtc_scan_display #(
  parameter int TICK_DIV   = 50000000,
  parameter int SCAN_DIV   = 50000,
  parameter int NUM_DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic                  mode,
  input  logic                  load,
  input  logic [4:0]            load_h,
  input  logic [5:0]            load_m,
  input  logic [5:0]            load_s,
  output logic [7:0]            seg,
  output logic [NUM_DIGITS-1:0] digit_sel,
  output logic                  sec_tick,
  output logic                  done,
  output logic                  load_err
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_HALF = PW'(TICK_DIV / 2);
  localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);
  localparam logic [2:0] IDX_MAX = 3'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_RESET = {{(NUM_DIGITS-1){1'b1}}, 1'b0};

  logic [4:0]    hrs, h_n;
  logic [5:0]    mins, m_n;
  logic [5:0]    secs, s_n;
  logic [PW-1:0] presc, presc_n;
  logic [SW-1:0] scan_cnt;
  logic [2:0]    idx;
  logic          load_ok;
  logic          tick;
  logic          done_n;

  // ---------------------------------------------------------------- time core
  always_comb begin
    h_n     = hrs;
    m_n     = mins;
    s_n     = secs;
    presc_n = presc;
    done_n  = 1'b0;
    load_ok = (load_h <= 5'd23) && (load_m <= 6'd59) && (load_s <= 6'd59);
    // A load in the same cycle as the terminal count swallows the tick,
    // whether or not the load itself is accepted.
    tick    = run && !load && (presc == PRESC_MAX);

    if (load) begin
      if (load_ok) begin
        h_n     = load_h;
        m_n     = load_m;
        s_n     = load_s;
        presc_n = '0;
      end
    end else if (run) begin
      if (presc == PRESC_MAX) begin
        presc_n = '0;
        if (!mode) begin
          if (secs == 6'd59) begin
            s_n = '0;
            if (mins == 6'd59) begin
              m_n = '0;
              h_n = (hrs == 5'd23) ? 5'd0 : hrs + 5'd1;
            end else begin
              m_n = mins + 6'd1;
            end
          end else begin
            s_n = secs + 6'd1;
          end
        end else begin
          // Only the step from 00:00:01 lands on zero; a tick at zero holds.
          done_n = (hrs == 5'd0) && (mins == 6'd0) && (secs == 6'd1);
          if (secs != 6'd0) begin
            s_n = secs - 6'd1;
          end else if (mins != 6'd0) begin
            m_n = mins - 6'd1;
            s_n = 6'd59;
          end else if (hrs != 5'd0) begin
            h_n = hrs - 5'd1;
            m_n = 6'd59;
            s_n = 6'd59;
          end
        end
      end else begin
        presc_n = presc + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hrs      <= '0;
      mins     <= '0;
      secs     <= '0;
      presc    <= '0;
      sec_tick <= 1'b0;
      done     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      hrs      <= h_n;
      mins     <= m_n;
      secs     <= s_n;
      presc    <= presc_n;
      sec_tick <= tick;
      done     <= done_n;
      load_err <= load && !load_ok;
    end
  end

  // ------------------------------------------------------------- display scan
  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 8'hC0;
      4'd1:    seg_code = 8'hF9;
      4'd2:    seg_code = 8'hA4;
      4'd3:    seg_code = 8'hB0;
      4'd4:    seg_code = 8'h99;
      4'd5:    seg_code = 8'h92;
      4'd6:    seg_code = 8'h82;
      4'd7:    seg_code = 8'hF8;
      4'd8:    seg_code = 8'h80;
      4'd9:    seg_code = 8'h90;
      default: seg_code = 8'hFF;
    endcase
  endfunction

  logic [5:0]            field;
  logic [3:0]            digit;
  logic                  dp_on;
  logic [7:0]            seg_n;
  logic [NUM_DIGITS-1:0] sel_n;

  always_comb begin
    case (idx)
      3'd0, 3'd1: field = secs;
      3'd2, 3'd3: field = mins;
      default:    field = {1'b0, hrs};
    endcase
    // Odd indices are tens digits, even indices are ones digits.
    digit = idx[0] ? 4'(field / 6'd10) : 4'(field % 6'd10);
    dp_on = ((idx == 3'd2) || ((NUM_DIGITS == 6) && (idx == 3'd4))) &&
            (!run || (presc < PRESC_HALF));
    seg_n = seg_code(digit);
    if (dp_on) seg_n[7] = 1'b0;
    sel_n = ~(NUM_DIGITS'(1) << idx);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt  <= '0;
      idx       <= '0;
      seg       <= 8'hC0;
      digit_sel <= SEL_RESET;
    end else begin
      seg       <= seg_n;
      digit_sel <= sel_n;
      if (scan_cnt == SCAN_MAX) begin
        scan_cnt <= '0;
        idx      <= (idx == IDX_MAX) ? 3'd0 : idx + 3'd1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rtc_scan_display.sv
module tb_rtc_scan_display;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       run = 1'b0;
  logic       mode = 1'b0;
  logic       load = 1'b0;
  logic [4:0] load_h = '0;
  logic [5:0] load_m = '0;
  logic [5:0] load_s = '0;

  logic [7:0] seg6, seg4;
  logic [5:0] sel6;
  logic [3:0] sel4;
  logic       st6, done6, err6, st4, done4, err4;

  rtc_scan_display #(.TICK_DIV(4), .SCAN_DIV(2), .NUM_DIGITS(6)) u6 (
    .clk(clk), .rst(rst), .run(run), .mode(mode), .load(load),
    .load_h(load_h), .load_m(load_m), .load_s(load_s),
    .seg(seg6), .digit_sel(sel6), .sec_tick(st6), .done(done6), .load_err(err6)
  );

  rtc_scan_display #(.TICK_DIV(4), .SCAN_DIV(2), .NUM_DIGITS(4)) u4 (
    .clk(clk), .rst(rst), .run(run), .mode(mode), .load(load),
    .load_h(load_h), .load_m(load_m), .load_s(load_s),
    .seg(seg4), .digit_sel(sel4), .sec_tick(st4), .done(done4), .load_err(err4)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    load   = 1'b1;
    load_h = h;
    load_m = m;
    load_s = s;
    step(1);
    load   = 1'b0;
  endtask

  logic [7:0] exp_seg [0:5];
  bit         found;
  logic [5:0] prev6;
  logic [3:0] prev4;

  initial begin
    exp_seg[0] = 8'h82; exp_seg[1] = 8'h92; exp_seg[2] = 8'h19;
    exp_seg[3] = 8'hB0; exp_seg[4] = 8'h24; exp_seg[5] = 8'hF9;

    // 1: reset state, held and after release
    step(2);
    chk("rst_seg", 32'(seg6), 32'(8'hC0));
    chk("rst_sel", 32'(sel6), 32'(6'b111110));
    chk("rst_pulses", 32'({st6, done6, err6}), 32'(3'b000));
    rst = 1'b1;
    step(1);
    chk("rel_seg", 32'(seg6), 32'(8'hC0));
    chk("rel_sel6", 32'(sel6), 32'(6'b111110));
    chk("rel_sel4", 32'(sel4), 32'(4'b1110));
    chk("rel_time", 32'({u6.hrs, u6.mins, u6.secs}), 32'(17'd0));

    // 2: clock mode rollover
    mode = 1'b0;
    run  = 1'b1;
    do_load(5'd23, 6'd59, 6'd58);
    chk("up_load", 32'({u6.hrs, u6.mins, u6.secs}), 32'({5'd23, 6'd59, 6'd58}));
    step(3);
    chk("up_notick", 32'(st6), 32'(1'b0));
    step(1);
    chk("up_t1", 32'({u6.hrs, u6.mins, u6.secs}), 32'({5'd23, 6'd59, 6'd59}));
    chk("up_tick1", 32'(st6), 32'(1'b1));
    step(1);
    chk("up_tick_end", 32'(st6), 32'(1'b0));
    step(3);
    chk("up_wrap", 32'({u6.hrs, u6.mins, u6.secs}), 32'(17'd0));
    chk("up_tick2", 32'(st6), 32'(1'b1));

    // 3: countdown with a single done
    mode = 1'b1;
    do_load(5'd0, 6'd0, 6'd2);
    step(4);
    chk("dn_t1", 32'({u6.hrs, u6.mins, u6.secs}), 32'(17'd1));
    chk("dn_nodone", 32'(done6), 32'(1'b0));
    step(4);
    chk("dn_t0", 32'({u6.hrs, u6.mins, u6.secs}), 32'(17'd0));
    chk("dn_done", 32'(done6), 32'(1'b1));
    step(1);
    chk("dn_done_end", 32'(done6), 32'(1'b0));
    step(3);
    chk("dn_hold", 32'({u6.hrs, u6.mins, u6.secs}), 32'(17'd0));
    chk("dn_hold_tick", 32'(st6), 32'(1'b1));
    chk("dn_hold_nodone", 32'(done6), 32'(1'b0));

    // 3b: borrow across minutes and hours
    do_load(5'd1, 6'd0, 6'd0);
    step(4);
    chk("dn_borrow", 32'({u6.hrs, u6.mins, u6.secs}), 32'({5'd0, 6'd59, 6'd59}));

    // load of zero produces no done
    run = 1'b0;
    do_load(5'd0, 6'd0, 6'd0);
    chk("ld0_nodone", 32'(done6), 32'(1'b0));
    step(1);
    chk("ld0_nodone2", 32'(done6), 32'(1'b0));

    // 4: load validation and priority over tick
    do_load(5'd0, 6'd0, 6'd5);
    run = 1'b1;
    step(2);
    chk("v_presc2", 32'(u6.presc), 32'(2));
    load = 1'b1; load_h = 5'd24; load_m = 6'd0; load_s = 6'd0;
    step(1);
    chk("bad_h_err", 32'(err6), 32'(1'b1));
    chk("bad_h_time", 32'({u6.hrs, u6.mins, u6.secs}), 32'(17'd5));
    chk("bad_h_presc", 32'(u6.presc), 32'(2));
    load = 1'b0;
    step(1);
    chk("bad_h_err_end", 32'(err6), 32'(1'b0));
    chk("v_presc3", 32'(u6.presc), 32'(3));
    load = 1'b1; load_h = 5'd12; load_m = 6'd60; load_s = 6'd0;
    step(1);
    chk("bad_m_err", 32'(err6), 32'(1'b1));
    chk("bad_m_time", 32'({u6.hrs, u6.mins, u6.secs}), 32'(17'd5));
    chk("bad_m_presc", 32'(u6.presc), 32'(3));
    load_h = 5'd10; load_m = 6'd20; load_s = 6'd30;
    step(1);
    load = 1'b0;
    chk("prio_time", 32'({u6.hrs, u6.mins, u6.secs}), 32'({5'd10, 6'd20, 6'd30}));
    chk("prio_presc", 32'(u6.presc), 32'(0));
    chk("prio_noerr", 32'(err6), 32'(1'b0));

    // 5: scan sequence, run=0 keeps the decimal points lit
    run  = 1'b0;
    mode = 1'b0;
    do_load(5'd12, 6'd34, 6'd56);
    step(1);
    found = 1'b0;
    prev6 = sel6;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1);
      if (sel6 == 6'b111110 && prev6 != 6'b111110) found = 1'b1;
      prev6 = sel6;
    end
    chk("align6", 32'(found), 32'(1'b1));
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("scan6_seg%0d", k), 32'(seg6), 32'(exp_seg[k % 6]));
      chk($sformatf("scan6_sel%0d", k), 32'(sel6), 32'(6'b111111 ^ (6'b000001 << (k % 6))));
      step(2);
    end
    found = 1'b0;
    prev4 = sel4;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1);
      if (sel4 == 4'b1110 && prev4 != 4'b1110) found = 1'b1;
      prev4 = sel4;
    end
    chk("align4", 32'(found), 32'(1'b1));
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("scan4_seg%0d", k), 32'(seg4), 32'(exp_seg[k % 4]));
      chk($sformatf("scan4_sel%0d", k), 32'(sel4), 32'(4'b1111 ^ (4'b0001 << (k % 4))));
      step(2);
    end

    // 6: asynchronous reset mid-count and mid-scan
    run = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1);
      if (sel4 == 4'b1011) found = 1'b1;
    end
    chk("mid_scan", 32'(found), 32'(1'b1));
    #2 rst = 1'b0;
    #1;
    chk("arst_seg6", 32'(seg6), 32'(8'hC0));
    chk("arst_sel6", 32'(sel6), 32'(6'b111110));
    chk("arst_seg4", 32'(seg4), 32'(8'hC0));
    chk("arst_sel4", 32'(sel4), 32'(4'b1110));
    chk("arst_time", 32'({u6.hrs, u6.mins, u6.secs}), 32'(17'd0));
    chk("arst_presc", 32'(u6.presc), 32'(0));
    chk("arst_pulses", 32'({st4, done4, err4}), 32'(3'b000));
    step(1);
    rst = 1'b1;
    step(4);
    chk("resume6", 32'({u6.hrs, u6.mins, u6.secs}), 32'(17'd1));
    chk("resume4", 32'({u4.hrs, u4.mins, u4.secs}), 32'(17'd1));
    for (int k = 0; k < 12; k++) begin
      step(1);
      chk($sformatf("sel4_legal%0d", k), 32'((sel4 == 4'b1110) || (sel4 == 4'b1101) ||
                                               (sel4 == 4'b1011) || (sel4 == 4'b0111)), 32'(1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rtc_scan_display.md
Name: rtc_scan_display

Overview:
Parametrised time-of-day / countdown core with a multiplexed common-anode 7-segment driver. It keeps HH:MM:SS counters from a programmable prescaler and supports clock (count-up) and countdown modes, with validated loading. It scans 4 or 6 digits and drives segment and digit-select pins directly at the board top level.

Parameters:
TICK_DIV, 50000000, clk cycles per second tick (>=2)
SCAN_DIV, 50000, clk cycles each digit stays selected (>=1)
NUM_DIGITS, 6, digits driven: 6 = HH MM SS, 4 = MM SS (only 4 or 6 legal)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
run  in  1  1 = prescaler advances; 0 = prescaler and time frozen
mode  in  1  0 = clock (count up), 1 = countdown
load  in  1  one-cycle strobe: load load_h/m/s
load_h  in  5  hours to load, 0..23
load_m  in  6  minutes to load, 0..59
load_s  in  6  seconds to load, 0..59
seg  out  8  {dp,g,f,e,d,c,b,a}, active-low
digit_sel  out  NUM_DIGITS  one-hot active-low digit enable
sec_tick  out  1  one-cycle pulse per elapsed second
done  out  1  one-cycle pulse when countdown reaches 00:00:00
load_err  out  1  one-cycle pulse when a load is rejected

Behaviour:
- Reset (async, rst=0): hours/minutes/seconds=0, prescaler=0, scan counter=0, digit index=0; seg=8'hC0, digit_sel=all ones except bit0=0, sec_tick=done=load_err=0.
- Prescaler counts 0..TICK_DIV-1 while run=1. A tick occurs in the cycle it equals TICK_DIV-1; it then wraps to 0. sec_tick is registered and is high the cycle after the tick.
- Clock mode on tick: seconds+1. 59 wraps to 0 with carry to minutes. Minutes 59 wraps to 0 with carry to hours. 23:59:59 -> 00:00:00. No value ever exceeds 23/59/59.
- Countdown mode on tick: decrement with borrow (00:01:00 -> 00:00:59, 01:00:00 -> 00:59:59).
  - The transition into 00:00:00 raises done the next cycle.
  - A tick at 00:00:00 leaves time unchanged, with no done; sec_tick still pulses.
- Load takes priority over a same-cycle tick.
  - Valid (h<=23, m<=59, s<=59): time is replaced and the prescaler is cleared to 0. No done is generated by the load itself, even if the loaded value is 00:00:00.
  - Invalid: time and prescaler are unchanged, and load_err pulses the next cycle.
- Load is accepted regardless of run. A mode change takes effect at the next tick.
- Digit map: idx0 = sec ones, 1 = sec tens, 2 = min ones, 3 = min tens, 4 = hr ones, 5 = hr tens.
  - NUM_DIGITS=4 uses idx 0..3; hours keep counting but are not displayed.
- Scan counter counts 0..SCAN_DIV-1. On wrap, idx advances and wraps NUM_DIGITS-1 -> 0.
  - seg and digit_sel are both registered from the same (idx, time, prescaler) snapshot, so they always change in the same cycle.
  - Time changes appear on seg at most 1 cycle later.
- Segment codes 0..9: C0, F9, A4, B0, 99, 92, 82, F8, 80, 90 (dp bit=1, off).
- Decimal point (bit7 forced 0) is lit on idx2, and on idx4 when NUM_DIGITS=6. It lights only while prescaler < TICK_DIV/2, or at all times when run=0.
- Reset mid-operation: all state returns to reset values immediately. Counting resumes from 00:00:00 after rst deasserts, and pulses in flight are lost.

Test Plan:
1. Reset, then release with no stimulus -> seg=8'hC0, digit_sel=6'b111110, sec_tick/done/load_err=0, time 00:00:00.
2. TICK_DIV=4, mode=0, load 23:59:58, run=1 -> after 4 cycles 23:59:59, after 8 cycles 00:00:00, one sec_tick every 4 cycles.
3. TICK_DIV=4, mode=1, load 00:00:02, run=1 -> 00:00:01 then 00:00:00. Exactly one done pulse, on the 2nd tick. Later ticks keep 00:00:00 with no done.
4. Load 24:00:00, then 12:60:00, then load and tick in the same cycle -> first two: load_err pulse, time unchanged. Third: load wins and prescaler=0.
5. SCAN_DIV=2, NUM_DIGITS=6, run=0, load 12:34:56 -> seg sequence 82, 92, 19, B0, 24, F9 with digit_sel 111110 .. 011111, then repeats.
6. NUM_DIGITS=4, run=1, assert rst mid-count and mid-scan -> outputs return to reset values immediately. digit_sel cycles 1110, 1101, 1011, 0111 only.
